// File: rtl/mac_rx_os_decoder_if.sv
// Receive-byte stream and decoder results for mac_rx_os_decoder.
// The master side drives PHY bytes in; the slave side is the decoder.
`timescale 1ns/1ps

interface mac_rx_os_decoder_if #(
    parameter int CNT_W = 4
);
    logic [7:0]       rxdata;
    logic             rxdatak;
    logic             rxvalid;
    logic             ts1_det;
    logic             ts2_det;
    logic             skp_det;
    logic             os_err;
    logic [39:0]      ts_bytes;
    logic [CNT_W-1:0] ts_consec;

    modport master (
        output rxdata, rxdatak, rxvalid,
        input  ts1_det, ts2_det, skp_det, os_err, ts_bytes, ts_consec
    );

    modport slave (
        input  rxdata, rxdatak, rxvalid,
        output ts1_det, ts2_det, skp_det, os_err, ts_bytes, ts_consec
    );
endinterface

// File: rtl/mac_rx_os_decoder.sv
// Byte-serial SKP/TS1/TS2 ordered-set decoder with consecutive-TS counting.
// OZ_RXOS_SKP_EN: when defined, SKP sets are decoded; otherwise SKP after COM is an error.
`timescale 1ns/1ps

module mac_rx_os_decoder #(
    parameter int CNT_W = 4
) (
    input  logic                        clk,
    input  logic                        rstn,
    mac_rx_os_decoder_if.slave          rxIf
);

    typedef enum logic [2:0] {HUNT, HDR, SKP_BODY, TS_FIELD, TS_ID} state_t;

    localparam logic [7:0]       SYM_COM   = 8'hBC;
    localparam logic [7:0]       SYM_SKP   = 8'h1C;
    localparam logic [7:0]       SYM_TS1ID = 8'h4A;
    localparam logic [7:0]       SYM_TS2ID = 8'h45;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           r_state, w_stateNext;
    logic [3:0]       r_idx, w_idxNext;
    logic [39:0]      r_cap, w_capNext;
    logic             r_isTs2, w_isTs2Next;
    logic             r_ts1Det, w_ts1DetNext;
    logic             r_ts2Det, w_ts2DetNext;
    logic             r_skpDet, w_skpDetNext;
    logic             r_osErr, w_osErrNext;
    logic [39:0]      r_tsBytes, w_tsBytesNext;
    logic [CNT_W-1:0] r_tsConsec, w_tsConsecNext;
    logic             r_prevValid, w_prevValidNext;
    logic             r_prevTs2, w_prevTs2Next;
    logic [39:0]      r_prevBytes, w_prevBytesNext;
    logic             w_fail, w_done;

    logic w_isCom, w_isSkp, w_isTs1Id, w_isTs2Id;
    assign w_isCom   =  rxIf.rxdatak && (rxIf.rxdata == SYM_COM);
    assign w_isSkp   =  rxIf.rxdatak && (rxIf.rxdata == SYM_SKP);
    assign w_isTs1Id = !rxIf.rxdatak && (rxIf.rxdata == SYM_TS1ID);
    assign w_isTs2Id = !rxIf.rxdatak && (rxIf.rxdata == SYM_TS2ID);

    // r_idx holds the number of the next byte expected within the current set.
    always_comb begin
        w_stateNext     = r_state;
        w_idxNext       = r_idx;
        w_capNext       = r_cap;
        w_isTs2Next     = r_isTs2;
        w_ts1DetNext    = 1'b0;
        w_ts2DetNext    = 1'b0;
        w_skpDetNext    = 1'b0;
        w_osErrNext     = 1'b0;
        w_tsBytesNext   = r_tsBytes;
        w_tsConsecNext  = r_tsConsec;
        w_prevValidNext = r_prevValid;
        w_prevTs2Next   = r_prevTs2;
        w_prevBytesNext = r_prevBytes;
        w_fail          = 1'b0;
        w_done          = 1'b0;

        if (rxIf.rxvalid) begin
            case (r_state)
                HUNT: begin
                    if (w_isCom) w_stateNext = HDR;
                end
                HDR: begin
                    if (w_isSkp) begin
`ifdef OZ_RXOS_SKP_EN
                        w_stateNext = SKP_BODY;
                        w_idxNext   = 4'd2;
`else
                        w_fail      = 1'b1;
`endif
                    end else begin
                        w_capNext[7:0] = rxIf.rxdata;
                        w_idxNext      = 4'd2;
                        w_stateNext    = TS_FIELD;
                    end
                end
`ifdef OZ_RXOS_SKP_EN
                SKP_BODY: begin
                    if (!w_isSkp) begin
                        w_fail = 1'b1;
                    end else if (r_idx == 4'd3) begin
                        w_skpDetNext = 1'b1;
                        w_stateNext  = HUNT;
                    end else begin
                        w_idxNext = r_idx + 4'd1;
                    end
                end
`endif
                TS_FIELD: begin
                    w_capNext[8*(r_idx-4'd1) +: 8] = rxIf.rxdata;
                    w_idxNext = r_idx + 4'd1;
                    if (r_idx == 4'd5) w_stateNext = TS_ID;
                end
                TS_ID: begin
                    if (r_idx == 4'd6) begin
                        if (w_isTs1Id || w_isTs2Id) begin
                            w_isTs2Next = w_isTs2Id;
                            w_idxNext   = 4'd7;
                        end else begin
                            w_fail = 1'b1;
                        end
                    end else if (r_isTs2 ? w_isTs2Id : w_isTs1Id) begin
                        if (r_idx == 4'd15) w_done = 1'b1;
                        else                w_idxNext = r_idx + 4'd1;
                    end else begin
                        w_fail = 1'b1;
                    end
                end
                default: w_stateNext = HUNT;
            endcase
        end

        // A COM that breaks a set is also the start of the next one.
        if (w_fail) begin
            w_osErrNext     = 1'b1;
            w_tsConsecNext  = '0;
            w_prevValidNext = 1'b0;
            w_stateNext     = w_isCom ? HDR : HUNT;
        end

        if (w_done) begin
            w_stateNext   = HUNT;
            w_ts1DetNext  = !r_isTs2;
            w_ts2DetNext  = r_isTs2;
            w_tsBytesNext = r_cap;
            if (r_prevValid && (r_prevTs2 == r_isTs2) && (r_prevBytes == r_cap) &&
                (r_tsConsec != '0)) begin
                w_tsConsecNext = (r_tsConsec == CNT_MAX) ? r_tsConsec : r_tsConsec + CNT_ONE;
            end else begin
                w_tsConsecNext = CNT_ONE;
            end
            w_prevValidNext = 1'b1;
            w_prevTs2Next   = r_isTs2;
            w_prevBytesNext = r_cap;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= HUNT;
            r_idx       <= 4'd0;
            r_cap       <= '0;
            r_isTs2     <= 1'b0;
            r_ts1Det    <= 1'b0;
            r_ts2Det    <= 1'b0;
            r_skpDet    <= 1'b0;
            r_osErr     <= 1'b0;
            r_tsBytes   <= '0;
            r_tsConsec  <= '0;
            r_prevValid <= 1'b0;
            r_prevTs2   <= 1'b0;
            r_prevBytes <= '0;
        end else begin
            r_state     <= w_stateNext;
            r_idx       <= w_idxNext;
            r_cap       <= w_capNext;
            r_isTs2     <= w_isTs2Next;
            r_ts1Det    <= w_ts1DetNext;
            r_ts2Det    <= w_ts2DetNext;
            r_skpDet    <= w_skpDetNext;
            r_osErr     <= w_osErrNext;
            r_tsBytes   <= w_tsBytesNext;
            r_tsConsec  <= w_tsConsecNext;
            r_prevValid <= w_prevValidNext;
            r_prevTs2   <= w_prevTs2Next;
            r_prevBytes <= w_prevBytesNext;
        end
    end

    assign rxIf.ts1_det   = r_ts1Det;
    assign rxIf.ts2_det   = r_ts2Det;
    assign rxIf.skp_det   = r_skpDet;
    assign rxIf.os_err    = r_osErr;
    assign rxIf.ts_bytes  = r_tsBytes;
    assign rxIf.ts_consec = r_tsConsec;

endmodule

// File: tb/tb_mac_rx_os_decoder.sv
// Self-checking bench for mac_rx_os_decoder: set-level reference model plus directed cases.
// Honours OZ_RXOS_SKP_EN the same way as the design.
`timescale 1ns/1ps

module tb_mac_rx_os_decoder;

    logic clk = 1'b0;
    logic rstn;

    always #5 clk = ~clk;

    mac_rx_os_decoder_if #(.CNT_W(4)) rxIf ();

    mac_rx_os_decoder #(.CNT_W(4)) dut (
        .clk  (clk),
        .rstn (rstn),
        .rxIf (rxIf)
    );

    int checkCount = 0;
    int passCount  = 0;
    int cyc        = 0;

    int ts1Cycles[$];
    int ts2Cycles[$];
    int errCycles[$];
    int skpCycles[$];

    // Reference model: bytes since the last COM are kept as a list and judged by position.
    bit         mHunt;
    logic [8:0] mBuf [0:15];
    int         mN;
    logic [3:0] expPulse;
    logic [39:0] expBytes;
    int         expConsec;
    bit         prevValid;
    bit         prevTs2;
    logic [39:0] prevBytes;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic modelReset();
        mHunt     = 1'b1;
        mN        = 0;
        expPulse  = 4'b0;
        expBytes  = '0;
        expConsec = 0;
        prevValid = 1'b0;
        prevTs2   = 1'b0;
        prevBytes = '0;
    endtask

    task automatic modelError(input bit isCom);
        expPulse[3] = 1'b1;
        expConsec   = 0;
        prevValid   = 1'b0;
        mHunt       = !isCom;
        mN          = 0;
    endtask

    task automatic modelByte(input logic [7:0] d, input logic k);
        bit         isCom;
        logic [8:0] sym;
        logic [8:0] id;
        logic [39:0] bytes;
        bit         t2;
        isCom = k && (d == 8'hBC);
        sym   = {k, d};
        if (mHunt) begin
            if (isCom) begin
                mHunt = 1'b0;
                mN    = 0;
            end
            return;
        end
        mBuf[mN] = sym;
        mN++;
        if (mBuf[0] == 9'h11C) begin
`ifdef OZ_RXOS_SKP_EN
            if (sym != 9'h11C) modelError(isCom);
            else if (mN == 3) begin
                expPulse[2] = 1'b1;
                mHunt       = 1'b1;
            end
`else
            modelError(isCom);
`endif
        end else if (mN >= 6) begin
            id = mBuf[5];
            if (!((id == 9'h04A) || (id == 9'h045)) || (sym != id)) begin
                modelError(isCom);
            end else if (mN == 15) begin
                bytes = {mBuf[4][7:0], mBuf[3][7:0], mBuf[2][7:0], mBuf[1][7:0], mBuf[0][7:0]};
                t2    = (id[7:0] == 8'h45);
                if (t2) expPulse[1] = 1'b1;
                else    expPulse[0] = 1'b1;
                if (prevValid && (prevTs2 == t2) && (prevBytes == bytes) && (expConsec != 0))
                    expConsec = (expConsec >= 15) ? 15 : expConsec + 1;
                else
                    expConsec = 1;
                expBytes  = bytes;
                prevValid = 1'b1;
                prevTs2   = t2;
                prevBytes = bytes;
                mHunt     = 1'b1;
            end
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        if (!rstn) modelReset();
        else begin
            expPulse = 4'b0;
            if (rxIf.rxvalid) modelByte(rxIf.rxdata, rxIf.rxdatak);
        end
        #1;
        checkOutput("pulses{err,skp,ts2,ts1}",
                    {rxIf.os_err, rxIf.skp_det, rxIf.ts2_det, rxIf.ts1_det}, expPulse);
        checkOutput("ts_bytes", rxIf.ts_bytes, expBytes);
        checkOutput("ts_consec", rxIf.ts_consec, expConsec);
        if (rxIf.ts1_det) ts1Cycles.push_back(cyc);
        if (rxIf.ts2_det) ts2Cycles.push_back(cyc);
        if (rxIf.os_err)  errCycles.push_back(cyc);
        if (rxIf.skp_det) skpCycles.push_back(cyc);
    end

    task automatic applyStimulus(input logic [7:0] d, input logic k);
        @(negedge clk);
        rxIf.rxdata  = d;
        rxIf.rxdatak = k;
        rxIf.rxvalid = 1'b1;
    endtask

    task automatic applyIdle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rxIf.rxvalid = 1'b0;
            rxIf.rxdata  = 8'($urandom);
            rxIf.rxdatak = 1'($urandom);
        end
    endtask

    // Sends COM + bytes 1..5 + ten ID bytes; comEdge is the clock edge that samples COM.
    task automatic sendTs(input bit ts2, input logic [39:0] b, input bit b1k, input int badAt,
                          input logic [8:0] badSym, input int stallAt, input int stallLen,
                          input int stopAt, output int comEdge);
        logic [8:0] sym;
        logic [7:0] id;
        id      = ts2 ? 8'h45 : 8'h4A;
        comEdge = 0;
        for (int i = 0; i < 16 && i < stopAt; i++) begin
            if (i == stallAt) applyIdle(stallLen);
            if (i == 0)      sym = 9'h1BC;
            else if (i <= 5) sym = {(i == 1) ? b1k : 1'b0, b[8*(i-1) +: 8]};
            else             sym = {1'b0, id};
            if (i == badAt) sym = badSym;
            applyStimulus(sym[7:0], sym[8]);
            if (i == 0) comEdge = cyc + 1;
        end
    endtask

    task automatic sendSkp();
        applyStimulus(8'hBC, 1'b1);
        repeat (3) applyStimulus(8'h1C, 1'b1);
    endtask

    localparam logic [39:0] PAT_A = 40'h000402F7F7;
    localparam logic [39:0] PAT_B = 40'h0A0B0C0D11;

    initial begin
        int e;
        int n0;
        logic [39:0] pool [0:2];
        bit          poolK [0:2];
        pool[0] = PAT_A; poolK[0] = 1'b1;
        pool[1] = PAT_B; poolK[1] = 1'b0;
        pool[2] = PAT_A; poolK[2] = 1'b0;

        rstn         = 1'b0;
        rxIf.rxvalid = 1'b0;
        rxIf.rxdata  = 8'h00;
        rxIf.rxdatak = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset pulses", {rxIf.os_err, rxIf.skp_det, rxIf.ts2_det, rxIf.ts1_det}, 4'b0);
        checkOutput("reset ts_bytes", rxIf.ts_bytes, 40'h0);
        checkOutput("reset ts_consec", rxIf.ts_consec, 4'd0);
        rstn = 1'b1;
        applyIdle(2);

        $display("[TB] eight back-to-back TS1");
        ts1Cycles.delete();
        for (int i = 0; i < 8; i++) sendTs(1'b0, PAT_A, 1'b1, -1, 9'h0, -1, 0, 16, e);
        applyIdle(3);
        checkOutput("b2b ts1 count", ts1Cycles.size(), 8);
        if (ts1Cycles.size() == 8)
            checkOutput("b2b ts1 spacing", ts1Cycles[7] - ts1Cycles[0], 112);
        checkOutput("b2b ts_consec", rxIf.ts_consec, 4'd8);
        checkOutput("b2b ts_bytes", rxIf.ts_bytes, 40'h000402F7F7);

        $display("[TB] TS1 x3 then TS2 with same bytes");
        ts2Cycles.delete();
        for (int i = 0; i < 3; i++) sendTs(1'b0, PAT_A, 1'b1, -1, 9'h0, -1, 0, 16, e);
        sendTs(1'b1, PAT_A, 1'b1, -1, 9'h0, -1, 0, 16, e);
        applyIdle(3);
        checkOutput("ts2 count", ts2Cycles.size(), 1);
        checkOutput("ts2 ts_consec", rxIf.ts_consec, 4'd1);

        $display("[TB] TS1 with corrupted byte 10");
        errCycles.delete();
        n0 = ts1Cycles.size();
        sendTs(1'b0, PAT_A, 1'b1, 10, 9'h045, -1, 0, 16, e);
        applyIdle(3);
        checkOutput("err count", errCycles.size(), 1);
        if (errCycles.size() == 1) checkOutput("err timing", errCycles[0] - e, 10);
        checkOutput("err no ts1", ts1Cycles.size() - n0, 0);
        checkOutput("err ts_consec", rxIf.ts_consec, 4'd0);
        sendTs(1'b0, PAT_A, 1'b1, -1, 9'h0, -1, 0, 16, e);
        applyIdle(3);
        checkOutput("post-err ts_consec", rxIf.ts_consec, 4'd1);

        $display("[TB] SKP between identical TS1");
        skpCycles.delete();
        sendTs(1'b0, PAT_B, 1'b0, -1, 9'h0, -1, 0, 16, e);
        sendSkp();
        sendTs(1'b0, PAT_B, 1'b0, -1, 9'h0, -1, 0, 16, e);
        applyIdle(3);
`ifdef OZ_RXOS_SKP_EN
        checkOutput("skp count", skpCycles.size(), 1);
        checkOutput("skp ts_consec", rxIf.ts_consec, 4'd2);
`else
        checkOutput("skp count", skpCycles.size(), 0);
        checkOutput("skp ts_consec", rxIf.ts_consec, 4'd1);
`endif

        $display("[TB] TS2 with 3-cycle stall at byte 7");
        ts2Cycles.delete();
        errCycles.delete();
        sendTs(1'b1, PAT_B, 1'b0, -1, 9'h0, 7, 3, 16, e);
        applyIdle(3);
        checkOutput("stall ts2 count", ts2Cycles.size(), 1);
        if (ts2Cycles.size() == 1) checkOutput("stall ts2 timing", ts2Cycles[0] - e, 18);
        checkOutput("stall no err", errCycles.size(), 0);

        $display("[TB] reset at byte 9 of a TS1");
        n0 = ts1Cycles.size();
        sendTs(1'b0, PAT_A, 1'b1, -1, 9'h0, -1, 0, 9, e);
        @(negedge clk);
        rxIf.rxvalid = 1'b0;
        rstn         = 1'b0;
        @(negedge clk);
        checkOutput("mid-reset pulses", {rxIf.os_err, rxIf.skp_det, rxIf.ts2_det, rxIf.ts1_det}, 4'b0);
        checkOutput("mid-reset ts_bytes", rxIf.ts_bytes, 40'h0);
        checkOutput("mid-reset ts_consec", rxIf.ts_consec, 4'd0);
        rstn = 1'b1;
        applyIdle(1);
        sendTs(1'b0, PAT_A, 1'b1, -1, 9'h0, -1, 0, 16, e);
        applyIdle(3);
        checkOutput("post-reset ts1 count", ts1Cycles.size() - n0, 1);
        checkOutput("post-reset ts_consec", rxIf.ts_consec, 4'd1);

        $display("[TB] saturation of ts_consec");
        for (int i = 0; i < 17; i++) sendTs(1'b0, PAT_A, 1'b1, -1, 9'h0, -1, 0, 16, e);
        applyIdle(2);
        checkOutput("saturated ts_consec", rxIf.ts_consec, 4'd15);

        $display("[TB] randomized traffic");
        for (int it = 0; it < 300; it++) begin
            int kind;
            int p;
            int badAt;
            int stallAt;
            logic [8:0] badSym;
            kind = $urandom_range(0, 99);
            if (kind < 65) begin
                p       = $urandom_range(0, 2);
                badAt   = ($urandom_range(0, 99) < 15) ? $urandom_range(6, 15) : -1;
                badSym  = ($urandom_range(0, 1) == 1) ? 9'h1BC : {1'b0, 8'($urandom)};
                stallAt = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 15) : -1;
                sendTs($urandom_range(0, 4) == 0, pool[p], poolK[p], badAt, badSym,
                       stallAt, $urandom_range(1, 3), 16, e);
            end else if (kind < 80) begin
                applyStimulus(8'hBC, 1'b1);
                for (int j = 0; j < 3; j++) begin
                    if ($urandom_range(0, 9) == 0) applyStimulus(8'($urandom), 1'b0);
                    else                           applyStimulus(8'h1C, 1'b1);
                end
            end else begin
                for (int j = 0; j < $urandom_range(1, 4); j++)
                    applyStimulus(8'($urandom), $urandom_range(0, 3) == 0);
            end
            if ($urandom_range(0, 2) == 0) applyIdle($urandom_range(1, 2));
        end
        applyIdle(4);

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
